// File: rtl/sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_responder_pkg
//   Shared definitions for the SRAM-side responder:
//     state_t    - FSM state encodings (S_IDLE .. S_WR_DONE)
//     clog2      - ceiling log2 helper for parameter-derived widths
//     cnt_width  - width of the latency counter for the given latencies
//   No ports; imported by sram_responder and sram_responder_array.
// ---------------------------------------------------------------------------
package sram_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_DRIVE = 3'd2,
    S_WR_WAIT  = 3'd3,
    S_WR_DONE  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // The counter only has to reach LAT-1 of the longer latency, but a
  // zero-width counter is not legal, so it is never narrower than one bit.
  function automatic int cnt_width(input int read_lat, input int write_lat);
    int longest;
    longest = (read_lat > write_lat) ? read_lat : write_lat;
    return (clog2(longest) < 1) ? 1 : clog2(longest);
  endfunction

endpackage

// File: rtl/sram_responder_array.sv
// ---------------------------------------------------------------------------
// sram_responder_array
//   MEM_WORDS x DATA_W word storage behind the responder. One synchronous
//   write port and one synchronous read port, no reset (contents survive a
//   responder reset). A read and a write to the same index on the same edge
//   return the newly written word.
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   write strobe
//   wr_idx   in   write word index
//   wr_data  in   write data
//   rd_idx   in   read word index, sampled every edge
//   rd_data  out  registered read data
// ---------------------------------------------------------------------------
module sram_responder_array
  import sram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 2048,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Write-first: a same-edge collision forwards the incoming word so a
  // reader never sees the stale value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (wr_en && (wr_idx == rd_idx)) rd_data <= wr_data;
    else                             rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//   Device end of the external SRAM bus. Stores words, answers reads after
//   READ_LAT stable-address edges, commits a write after WRITE_LAT stable
//   edges with WE_N low (once per low pulse), and releases DQ combinationally
//   as soon as the initiator pulls WE_N low.
// Optional feature (macro SRAM_RESP_STATS_EN): adds saturating rd_count,
//   wr_count and oor_count outputs. Without the macro they do not exist.
// Ports:
//   clk            in     rising-edge clock
//   rst            in     asynchronous active-low reset
//   SRAM_Addr      in     word address from the initiator
//   SRAM_WE_N      in     0 = write (initiator drives DQ), 1 = read
//   SRAM_DQ        inout  bidirectional data
//   dbg_rd_valid   out    DQ carries valid data for the current address
//   dbg_wr_commit  out    one-cycle pulse after a committing edge
//   rd_count       out    completed reads        (SRAM_RESP_STATS_EN only)
//   wr_count       out    committed writes       (SRAM_RESP_STATS_EN only)
//   oor_count      out    out-of-range accesses  (SRAM_RESP_STATS_EN only)
// ---------------------------------------------------------------------------
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 2048,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_Addr,
  input  logic              SRAM_WE_N,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              dbg_rd_valid,
  output logic              dbg_wr_commit
`ifdef SRAM_RESP_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [15:0]       oor_count
`endif
);

  localparam int IDX_W = clog2(MEM_WORDS);
  localparam int CNT_W = cnt_width(READ_LAT, WRITE_LAT);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] arr_rd_data;
  logic              addr_stable;
  logic              addr_in_range;
  logic              rd_complete;
  logic              wr_reach;
  logic              wr_commit;
  logic              dq_oe;

  assign addr_stable   = (SRAM_Addr == addr_q);
  assign addr_in_range = (32'(SRAM_Addr) < 32'(MEM_WORDS));

  // wr_reach is the edge a write finishes its latency; only an in-range
  // one actually touches the array.
  assign rd_complete = (state == S_RD_WAIT) && SRAM_WE_N && addr_stable && (cnt == RD_LAST);
  assign wr_reach    = (state == S_WR_WAIT) && !SRAM_WE_N && addr_stable && (cnt == WR_LAST);
  assign wr_commit   = wr_reach && addr_in_range;

  // Enable is decoded from the live WE_N input, not a register, so the bus
  // is released in the very cycle the initiator starts driving it.
  assign dq_oe   = rst & SRAM_WE_N & (state == S_RD_DRIVE);
  assign SRAM_DQ = dq_oe ? rd_data_q : 'z;

  sram_responder_array #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_commit),
    .wr_idx  (SRAM_Addr[IDX_W-1:0]),
    .wr_data (SRAM_DQ),
    .rd_idx  (SRAM_Addr[IDX_W-1:0]),
    .rd_data (arr_rd_data)
  );

  // Responder FSM. The array output sampled on the previous edge already
  // holds mem[addr]: completion requires a stable address, so the previous
  // edge read the same word, and no write can land in between.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      rd_data_q     <= '0;
      dbg_rd_valid  <= 1'b0;
      dbg_wr_commit <= 1'b0;
    end else begin
      addr_q        <= SRAM_Addr;
      dbg_rd_valid  <= 1'b0;
      dbg_wr_commit <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt   <= '0;
          state <= SRAM_WE_N ? S_RD_WAIT : S_WR_WAIT;
        end
        S_RD_WAIT: begin
          if (!SRAM_WE_N) begin
            state <= S_WR_WAIT;
            cnt   <= '0;
          end else if (!addr_stable) begin
            cnt <= '0;
          end else if (rd_complete) begin
            rd_data_q    <= addr_in_range ? arr_rd_data : '0;
            state        <= S_RD_DRIVE;
            dbg_rd_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_DRIVE: begin
          if (!SRAM_WE_N) begin
            state <= S_WR_WAIT;
            cnt   <= '0;
          end else if (!addr_stable) begin
            state <= S_RD_WAIT;
            cnt   <= '0;
          end else begin
            dbg_rd_valid <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (SRAM_WE_N) begin
            state <= S_RD_WAIT;
            cnt   <= '0;
          end else if (!addr_stable) begin
            cnt <= '0;
          end else if (wr_reach) begin
            state         <= S_WR_DONE;
            dbg_wr_commit <= addr_in_range;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_DONE: begin
          if (SRAM_WE_N) begin
            state <= S_RD_WAIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SRAM_RESP_STATS_EN
  // Saturating access statistics, bumped on the completing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      oor_count <= '0;
    end else begin
      if (rd_complete && (rd_count != '1)) rd_count <= rd_count + 1'b1;
      if (wr_commit && (wr_count != '1))   wr_count <= wr_count + 1'b1;
      if ((rd_complete || wr_reach) && !addr_in_range && (oor_count != '1))
        oor_count <= oor_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//   Directed scenarios followed by random traffic for sram_responder. A
//   behavioural model tracks the memory image and per-access stable-edge
//   streaks; DQ is pulled up so a released bus reads as all ones.
//   Stats ports are connected and checked when SRAM_RESP_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_sram_responder;

  localparam int MEM_WORDS = 2048;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 2;
  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic [18:0] sram_addr = '0;
  logic        sram_we_n = 1'b1;
  logic [31:0] drv_val   = '0;
  logic        drv_en    = 1'b0;
  wire  [31:0] sram_dq;
  logic        dbg_rd_valid;
  logic        dbg_wr_commit;
`ifdef SRAM_RESP_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [15:0] oor_count;
`endif

  assign sram_dq = drv_en ? drv_val : 'z;
  pullup dq_pull (sram_dq);

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_W    (19),
    .DATA_W    (32),
    .MEM_WORDS (MEM_WORDS),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .SRAM_Addr     (sram_addr),
    .SRAM_WE_N     (sram_we_n),
    .SRAM_DQ       (sram_dq),
    .dbg_rd_valid  (dbg_rd_valid),
    .dbg_wr_commit (dbg_wr_commit)
`ifdef SRAM_RESP_STATS_EN
    ,
    .rd_count      (rd_count),
    .wr_count      (wr_count),
    .oor_count     (oor_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory image plus "how many stable edges has the
  // current access seen" bookkeeping.
  logic [31:0] m_mem   [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  bit          m_started;
  logic [18:0] m_prev_addr;
  logic        m_prev_we_n;
  int          m_streak;
  bit          m_valid;
  bit          m_pulse;
  bit          m_done;
  logic [31:0] m_rd_value;
  bit          m_rd_known;
  int          m_rd, m_wr, m_oor;
  logic [31:0] setup_data [16];

  task automatic modelReset();
    m_started   = 1'b0;
    m_prev_addr = '0;
    m_prev_we_n = 1'b1;
    m_streak    = 0;
    m_valid     = 1'b0;
    m_pulse     = 1'b0;
    m_done      = 1'b0;
    m_rd = 0; m_wr = 0; m_oor = 0;
  endtask

  task automatic modelEdge(input logic [18:0] a, input logic w, input logic [31:0] d);
    bit          in_range;
    bit          stable;
    logic [10:0] idx;
    in_range = (int'(a) < MEM_WORDS);
    idx      = a[10:0];
    stable   = (a == m_prev_addr);
    m_pulse  = 1'b0;
    if (!m_started) begin
      m_started = 1'b1; m_streak = 0; m_valid = 1'b0; m_done = 1'b0;
    end else if (w != m_prev_we_n) begin
      m_streak = 0; m_valid = 1'b0; m_done = 1'b0;
    end else if (w) begin
      if (!stable) begin
        m_streak = 0; m_valid = 1'b0;
      end else if (!m_valid) begin
        m_streak++;
        if (m_streak == READ_LAT) begin
          m_valid = 1'b1;
          m_rd++;
          if (in_range) begin
            m_rd_value = m_mem[idx]; m_rd_known = m_known[idx];
          end else begin
            m_rd_value = '0; m_rd_known = 1'b1; m_oor++;
          end
        end
      end
    end else if (!m_done) begin
      if (!stable) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == WRITE_LAT) begin
          m_done = 1'b1;
          if (in_range) begin
            m_mem[idx] = d; m_known[idx] = 1'b1; m_pulse = 1'b1; m_wr++;
          end else m_oor++;
        end
      end
    end
    m_prev_addr = a;
    m_prev_we_n = w;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_rdv"}, 32'(dbg_rd_valid), 32'(m_valid));
    checkOutput({tag, "_wrc"}, 32'(dbg_wr_commit), 32'(m_pulse));
    if (!drv_en && (!m_valid || m_rd_known))
      checkOutput({tag, "_dq"}, sram_dq, m_valid ? m_rd_value : RELEASED);
`ifdef SRAM_RESP_STATS_EN
    checkOutput({tag, "_rdcnt"}, rd_count, 32'(m_rd));
    checkOutput({tag, "_wrcnt"}, wr_count, 32'(m_wr));
    checkOutput({tag, "_oorcnt"}, 32'(oor_count), 32'(m_oor));
`endif
  endtask

  // One bus edge: present inputs, let the DUT and model see the edge,
  // then sample 1 time unit later.
  task automatic applyStimulus(input logic [18:0] a, input logic w, input logic [31:0] d, input logic drv);
    sram_addr = a; sram_we_n = w; drv_val = d; drv_en = drv;
    @(posedge clk);
    modelEdge(a, w, drv ? d : RELEASED);
    #1;
  endtask

  task automatic doReset(input string tag);
    drv_en = 1'b0;
    rst    = 1'b0;
    #2;
    modelReset();
    checkOutput({tag, "_rdv"}, 32'(dbg_rd_valid), 32'd0);
    checkOutput({tag, "_wrc"}, 32'(dbg_wr_commit), 32'd0);
    checkOutput({tag, "_dq"}, sram_dq, RELEASED);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] randData();
    logic [31:0] v;
    v = $urandom;
    if (v == RELEASED) v = 32'h0000_0001;
    return v;
  endfunction

  initial begin
    int          commits;
    logic        cur_w;
    logic [18:0] cur_a;
    int          r;
    for (int i = 0; i < MEM_WORDS; i++) m_known[i] = 1'b0;
    modelReset();
    #12;
    doReset("rst0");

    // Preload words 0..15 through the bus, one WE_N low pulse each.
    for (int a = 0; a < 16; a++) begin
      setup_data[a] = (a == 5) ? 32'hDEAD_BEEF : randData();
      applyStimulus(19'(a), 1'b1, '0, 1'b0);
      checkModel("setup");
      repeat (3) begin
        applyStimulus(19'(a), 1'b0, setup_data[a], 1'b1);
        checkModel("setup");
      end
    end

    // Array contents survive reset; read of 5 after READ_LAT stable edges.
    doReset("rst1");
    applyStimulus(19'd5, 1'b1, '0, 1'b0); checkModel("t1_e1");
    checkOutput("t1_e1_released", sram_dq, RELEASED);
    applyStimulus(19'd5, 1'b1, '0, 1'b0); checkModel("t1_e2");
    checkOutput("t1_e2_released", sram_dq, RELEASED);
    applyStimulus(19'd5, 1'b1, '0, 1'b0); checkModel("t1_e3");
    checkOutput("t1_data", sram_dq, 32'hDEAD_BEEF);
    checkOutput("t1_valid", 32'(dbg_rd_valid), 32'd1);

    // Write 9 then read it back.
    repeat (3) begin
      applyStimulus(19'd9, 1'b0, 32'h1234_5678, 1'b1); checkModel("t2_wr");
    end
    checkOutput("t2_commit", 32'(dbg_wr_commit), 32'd1);
    applyStimulus(19'd9, 1'b0, 32'h1234_5678, 1'b1); checkModel("t2_hold");
    checkOutput("t2_pulse_end", 32'(dbg_wr_commit), 32'd0);
    repeat (3) begin
      applyStimulus(19'd9, 1'b1, '0, 1'b0); checkModel("t2_rd");
    end
    checkOutput("t2_readback", sram_dq, 32'h1234_5678);

    // WE_N low for 6 edges with changing DQ: exactly one commit.
    commits = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(19'd3, 1'b0, 32'hA5A5_0000 + 32'(i), 1'b1);
      checkModel("t3_wr");
      commits += int'(dbg_wr_commit);
    end
    checkOutput("t3_commits", 32'(commits), 32'd1);
    repeat (3) begin
      applyStimulus(19'd3, 1'b1, '0, 1'b0); checkModel("t3_rd");
    end
    checkOutput("t3_data", sram_dq, 32'hA5A5_0002);

    // Address change mid-read restarts the latency.
    applyStimulus(19'd4, 1'b1, '0, 1'b0); checkModel("t4_a4");
    applyStimulus(19'd4, 1'b1, '0, 1'b0); checkModel("t4_a4");
    applyStimulus(19'd7, 1'b1, '0, 1'b0); checkModel("t4_chg");
    applyStimulus(19'd7, 1'b1, '0, 1'b0); checkModel("t4_s1");
    checkOutput("t4_not_yet", sram_dq, RELEASED);
    applyStimulus(19'd7, 1'b1, '0, 1'b0); checkModel("t4_s2");
    checkOutput("t4_data", sram_dq, setup_data[7]);

    // WE_N falls while driving: released within the same cycle.
    sram_we_n = 1'b0;
    #1;
    checkOutput("t5_release", sram_dq, RELEASED);
    applyStimulus(19'd12, 1'b0, 32'h0BAD_F00D, 1'b1); checkModel("t5_wr");
    applyStimulus(19'd12, 1'b0, 32'h0BAD_F00D, 1'b1); checkModel("t5_wr");
    doReset("t5_rst");
    repeat (3) begin
      applyStimulus(19'd12, 1'b1, '0, 1'b0); checkModel("t5_rd");
    end
    checkOutput("t5_not_written", sram_dq, setup_data[12]);

    // Out-of-range read returns 0; out-of-range write never commits.
    repeat (3) begin
      applyStimulus(19'(MEM_WORDS + 1), 1'b1, '0, 1'b0); checkModel("t6_rd");
    end
    checkOutput("t6_oor_read", sram_dq, 32'd0);
    commits = 0;
    repeat (4) begin
      applyStimulus(19'(MEM_WORDS + 1), 1'b0, 32'h55AA_55AA, 1'b1); checkModel("t6_wr");
      commits += int'(dbg_wr_commit);
    end
    checkOutput("t6_no_commit", 32'(commits), 32'd0);
    repeat (3) begin
      applyStimulus(19'd1, 1'b1, '0, 1'b0); checkModel("t6_rd1");
    end
    checkOutput("t6_mem1", sram_dq, setup_data[1]);
`ifdef SRAM_RESP_STATS_EN
    checkOutput("t6_oor_count", 32'(oor_count), 32'd2);
`endif

    // Random traffic: addresses mostly held so accesses can complete.
    cur_w = 1'b1;
    cur_a = 19'd0;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 9) < 3) begin
        cur_w = 1'($urandom_range(0, 1));
        r     = int'($urandom_range(0, 19));
        cur_a = (r < 17) ? 19'(r % 16) : 19'(MEM_WORDS + r);
      end
      applyStimulus(cur_a, cur_w, randData(), !cur_w);
      checkModel("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
